// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter/sequencer for two requesters onto the main bus master port.
// Latency: grant and bus_valid one edge after req; done two edges after req at best.
// Backpressure: bus is held until bus_ack or TIMEOUT bus cycles; later requests wait in IDLE.
module main_bus_arbiter #(
  parameter int PAGE_W  = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [1:0]            req,
  input  logic [1:0]            req_rw,
  input  logic [2*PAGE_W-1:0]   req_page,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  bus_valid,
  output logic                  bus_rw,
  output logic [PAGE_W-1:0]     bus_page,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic                last, last_nxt;
  logic                id, id_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [1:0]          gnt_nxt, done_nxt;
  logic                err_nxt, bus_valid_nxt, bus_rw_nxt;
  logic [DATA_W-1:0]   rdata_nxt, bus_wdata_nxt;
  logic [PAGE_W-1:0]   bus_page_nxt;
  logic [ADDR_W-1:0]   bus_addr_nxt;
  logic                win;
  logic                timeout;

  // With both requesting, the one that was not served last wins.
  assign win     = (req == 2'b11) ? ~last : req[1];
  assign timeout = (timer == TMAX);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = BUS;
      BUS:     if (bus_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    last_nxt      = last;
    id_nxt        = id;
    timer_nxt     = timer;
    gnt_nxt       = gnt;
    done_nxt      = done;
    err_nxt       = err;
    rdata_nxt     = rdata;
    bus_valid_nxt = bus_valid;
    bus_rw_nxt    = bus_rw;
    bus_page_nxt  = bus_page;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    case (state)
      IDLE: begin
        gnt_nxt       = '0;
        done_nxt      = '0;
        err_nxt       = 1'b0;
        rdata_nxt     = '0;
        bus_valid_nxt = 1'b0;
        if (|req) begin
          id_nxt        = win;
          gnt_nxt       = win ? 2'b10 : 2'b01;
          timer_nxt     = '0;
          bus_valid_nxt = 1'b1;
          bus_rw_nxt    = req_rw[win];
          bus_page_nxt  = win ? req_page[2*PAGE_W-1:PAGE_W]   : req_page[PAGE_W-1:0];
          bus_addr_nxt  = win ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
          bus_wdata_nxt = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
      end
      BUS: begin
        // An ack on the final timer cycle still counts as a good completion.
        if (bus_ack) begin
          done_nxt      = id ? 2'b10 : 2'b01;
          err_nxt       = 1'b0;
          rdata_nxt     = bus_rw ? '0 : bus_rdata;
          bus_valid_nxt = 1'b0;
        end else if (timeout) begin
          done_nxt      = id ? 2'b10 : 2'b01;
          err_nxt       = 1'b1;
          rdata_nxt     = '0;
          bus_valid_nxt = 1'b0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      RESP: begin
        last_nxt  = id;
        gnt_nxt   = '0;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        rdata_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last      <= 1'b1;
      id        <= 1'b0;
      timer     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      bus_valid <= 1'b0;
      bus_rw    <= 1'b0;
      bus_page  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      last      <= last_nxt;
      id        <= id_nxt;
      timer     <= timer_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
      bus_valid <= bus_valid_nxt;
      bus_rw    <= bus_rw_nxt;
      bus_page  <= bus_page_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end

endmodule

// File: doc/main_bus_arbiter.md
# main_bus_arbiter

Two-requester arbiter and sequencer for the single master port of the main bus. Each requester (a CPU-side `processor_if` agent) posts one page/address read or write. The arbiter picks one round-robin, drives the bus transaction and waits for the memory acknowledge with a timeout. It then returns completion, read data and an error flag to the winning requester. It sits between the processor interfaces and the memory side of `main_bus_if`.

## Interface
- `PAGE_W`, 4, page field width
- `ADDR_W`, 16, address width
- `DATA_W`, 64, data width
- `TIMEOUT`, 16, maximum bus cycles waiting for `bus_ack` (≥2)

- `clk`  in  1  bus clock; all logic on rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `req`  in  2  per-requester request level, bit i = requester i
- `req_rw`  in  2  per-requester direction, 1 = write, 0 = read
- `req_page`  in  2×PAGE_W  per-requester page
- `req_addr`  in  2×ADDR_W  per-requester address
- `req_wdata`  in  2×DATA_W  per-requester write data
- `gnt`  out  2  one-hot grant, high for the whole owned transaction
- `done`  out  2  one-cycle completion pulse to the granted requester
- `err`  out  1  valid with `done`; 1 = timed out
- `rdata`  out  DATA_W  read data, valid with `done` on reads
- `bus_valid`  out  1  transaction request to memory
- `bus_rw`  out  1  1 = write
- `bus_page`  out  PAGE_W  page
- `bus_addr`  out  ADDR_W  address
- `bus_wdata`  out  DATA_W  write data
- `bus_ack`  in  1  memory completion, single-cycle
- `bus_rdata`  in  DATA_W  read data, valid with `bus_ack`

## Operation
- Three-state FSM: IDLE, BUS, RESP. All outputs are registered.
- **IDLE**:
  - If any `req` bit is set, pick the winner. With one requester, that one wins. With both, the requester that did not win last wins. The pointer `last` resets to 1, so requester 0 wins first.
  - Latch the winner's id, rw, page, addr and wdata. Set `gnt[id]`, clear the timer, go to BUS.
- **BUS**:
  - `bus_valid`=1 and the bus fields show the latched values, held stable.
  - Timer increments each cycle `bus_ack` is low.
  - `bus_ack`=1: capture `bus_rdata` into `rdata` on reads (writes leave `rdata`=0), `err`=0, go to RESP.
  - Timer reaches TIMEOUT−1 with `bus_ack` low: `rdata`=0, `err`=1, go to RESP.
  - `bus_ack` and the timeout in the same cycle: the ack wins and `err`=0.
- **RESP**:
  - `done[id]`=1 for one cycle. `gnt[id]` stays high. `bus_valid`=0.
  - Update `last`=id, go to IDLE. In IDLE, `gnt`, `done`, `err` and `rdata` return to 0.
- Latched fields decouple the bus from requester inputs. Changes to `req_*`, or `req` dropping, during BUS or RESP are ignored, and the transaction completes.
- `bus_ack` outside BUS is ignored.
- A requester wanting no further transaction deasserts `req` by the edge ending its `done` cycle. A still-high `req` is re-arbitrated in the next IDLE cycle.
- Reset (any time, including mid-transaction) forces:
  - state IDLE, `last`=1, timer 0;
  - `gnt`, `done`, `err`, `rdata` and all `bus_*` outputs to 0.
- The aborted transaction is not resumed.

## Timing
- Every transaction passes through one IDLE cycle, so back-to-back service gives at most one transaction per 3 cycles.
- `req` sampled high in IDLE at edge E:
  - `gnt` and `bus_valid` are high from E.
  - `bus_ack` high in the first BUS cycle is sampled at E+1, so `done` and `rdata` are valid in the cycle after E+1.
  - IDLE resumes after E+2.
- Minimum request-to-`done` latency is 2 cycles.
- An ack arriving k cycles late adds k cycles.
- Timeout: BUS lasts exactly TIMEOUT cycles, and `done`+`err` follow in the next cycle.
- Single-cycle `bus_ack` pulses are required. Holding `bus_ack` high longer has no additional effect.

## Test plan
- **Single read.** `req`=01, `req_rw`[0]=0, page 2, addr 32, memory acks 1 cycle after `bus_valid` with 64'd128. Required: `bus_page`=2, `bus_addr`=32, `gnt`=01, `done`=01 for exactly one cycle, `rdata`=128, `err`=0.
- **Write then read.** Requester 1 writes 64'd128 to page 2 addr 32, then reads the same location. Required: `bus_rw`=1 then 0, `bus_wdata`=128 on the write, `rdata`=128 on the read.
- **Contention.** `req`=11 held continuously from reset, ack immediate. Required: grant order 0,1,0,1, never two `gnt` bits set, one IDLE cycle between transactions.
- **Timeout.** No `bus_ack`, TIMEOUT=16. Required: `bus_valid` high exactly 16 cycles, then `done` with `err`=1 and `rdata`=0. Variant with `bus_ack` on cycle 16: `err`=0.
- **Input churn.** Change `req_addr` and drop `req` during BUS. Required: `bus_addr` stays at the latched value and the transaction completes with `done`.
- **Reset mid-transaction.** Assert `resetN`=0 during BUS. Required: all outputs 0 immediately. After release, `req`=11 is granted to requester 0 first.
